priority_request_gen: RTL and testbench



---
 rtl/priority_request_gen_if.sv | 33 +++
 rtl/priority_request_gen.sv | 147 ++++++++++++++
 tb/tb_priority_request_gen.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/priority_request_gen_if.sv
// priority_request_gen_if
// Request/grant bundle between the request sources, the priority
// generator and the consumer of the priority/use_priority pair.
// The winner output is named 'prio' because 'priority' is a reserved word.
// Bit meaning is unchanged: 1 = A wins, 0 = B wins.
//   master : request sources and consumer (drive req_a/req_b/grant_ack)
//   slave  : the generator itself (drives prio/use_priority/busy)
interface priority_request_gen_if;
   logic req_a;
   logic req_b;
   logic grant_ack;
   logic prio;
   logic use_priority;
   logic busy;

   modport master (
      output req_a,
      output req_b,
      output grant_ack,
      input  prio,
      input  use_priority,
      input  busy
   );

   modport slave (
      input  req_a,
      input  req_b,
      input  grant_ack,
      output prio,
      output use_priority,
      output busy
   );
endinterface

// File: rtl/priority_request_gen.sv
// priority_request_gen
// Arbitrates two asynchronous request levels (A, B) into a timed priority
// grant. Both requests are brought in through two-flop synchronizers. A
// small Moore FSM then debounces the chosen candidate, holds the grant
// until it is acknowledged or times out, and waits for both requests to go
// low before it re-arms. All outputs decode straight from registers.
// Optional build macro: PRIO_ROUND_ROBIN_EN. It makes simultaneous requests
// alternate between A and B. Without it, a tie always goes to A.
module priority_request_gen #(
   parameter int DEB_CYCLES  = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int CNT_W       = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   priority_request_gen_if.slave bus
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_DEBOUNCE = 2'd1;
   localparam logic [1:0] ST_GRANT    = 2'd2;
   localparam logic [1:0] ST_COOLDOWN = 2'd3;

   localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEB_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]       sync_meta_q;   // bit 0 = A, bit 1 = B
   logic [1:0]       sync_q;
   logic             sa;
   logic             sb;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cand_q, cand_d;
   logic             prio_q, prio_d;
   logic             cand_high;
   logic             tie_pick;

`ifdef PRIO_ROUND_ROBIN_EN
   logic             last_winner_q, last_winner_d;
   assign tie_pick = ~last_winner_q;
`else
   assign tie_pick = 1'b1;
`endif

   assign sa = sync_q[0];
   assign sb = sync_q[1];

   // two-flop synchronizer for both request levels
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta_q <= 2'b00;
         sync_q      <= 2'b00;
      end else begin
         sync_meta_q <= {bus.req_b, bus.req_a};
         sync_q      <= sync_meta_q;
      end
   end

   // next-state, counter and winner computation
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cand_d    = cand_q;
      prio_d    = prio_q;
      cand_high = cand_q ? sa : sb;
`ifdef PRIO_ROUND_ROBIN_EN
      last_winner_d = last_winner_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (sa | sb) begin
               state_d = ST_DEBOUNCE;
               cand_d  = (sa & sb) ? tie_pick : sa;
               cnt_d   = '0;
            end
         end
         ST_DEBOUNCE: begin
            // cnt counts cycles the candidate has stayed high after detection;
            // the other source is never promoted if the candidate drops
            if (!cand_high) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LIM) begin
               state_d = ST_GRANT;
               prio_d  = cand_q;
               cnt_d   = '0;
`ifdef PRIO_ROUND_ROBIN_EN
               last_winner_d = cand_q;
`endif
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_GRANT: begin
            // ack and timeout take the same exit, so coincidence needs no special case
            if (bus.grant_ack || (cnt_q == HOLD_LIM)) begin
               state_d = ST_COOLDOWN;
               cnt_d   = '0;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_COOLDOWN: begin
            if (!sa && !sb) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM and winner registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cand_q  <= 1'b0;
         prio_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
         prio_q  <= prio_d;
      end
   end

`ifdef PRIO_ROUND_ROBIN_EN
   // remembers the most recent grant winner for tie alternation
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_winner_q <= 1'b0;
      end else begin
         last_winner_q <= last_winner_d;
      end
   end
`endif

   assign bus.prio         = prio_q;
   assign bus.use_priority = (state_q == ST_GRANT);
   assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_priority_request_gen.sv
// tb_priority_request_gen
// Directed scenarios for latency, abort, acknowledge, tie, reset and
// timeout/ack coincidence, then randomized request/ack traffic. Every cycle
// is compared against a timestamp-based reference model of the grant rules.
module tb_priority_request_gen;

   localparam int DEB  = 4;
   localparam int HOLD = 16;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   priority_request_gen_if bus();

   priority_request_gen #(
      .DEB_CYCLES  (DEB),
      .HOLD_CYCLES (HOLD),
      .CNT_W       (5)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // ---------------- reference model ----------------
   typedef enum int {M_IDLE, M_DEB, M_GRANT, M_COOL} mphase_t;

   mphase_t m_phase;
   int      n;            // edge index since start
   int      deb_from;     // edge at which a request was first seen synchronized
   int      grant_from;   // edge at which the grant became visible
   bit      cand;
   bit      m_prio;
   bit      m_last;
   bit      qa[$];        // request history: oldest entry is what the FSM sees
   bit      qb[$];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, n);
      end
   endtask

   task automatic model_reset();
      m_phase = M_IDLE;
      m_prio  = 1'b0;
      m_last  = 1'b0;
      cand    = 1'b0;
      qa.delete();
      qb.delete();
      qa.push_back(1'b0); qa.push_back(1'b0);
      qb.push_back(1'b0); qb.push_back(1'b0);
   endtask

   task automatic model_edge(input bit ra, input bit rb, input bit ack);
      bit sa;
      bit sb;
      bit tie_cand;
      sa = qa.pop_front();
      sb = qb.pop_front();
      qa.push_back(ra);
      qb.push_back(rb);
      n++;
`ifdef PRIO_ROUND_ROBIN_EN
      tie_cand = ~m_last;
`else
      tie_cand = 1'b1;
`endif
      case (m_phase)
         M_IDLE: begin
            if (sa || sb) begin
               m_phase  = M_DEB;
               deb_from = n;
               cand     = (sa && sb) ? tie_cand : sa;
            end
         end
         M_DEB: begin
            if (!(cand ? sa : sb)) begin
               m_phase = M_IDLE;
            end else if (n - deb_from == DEB + 1) begin
               // request sampled at edge 0 is detected at edge 2 and granted at edge DEB+3
               m_phase    = M_GRANT;
               grant_from = n;
               m_prio     = cand;
               m_last     = cand;
            end
         end
         M_GRANT: begin
            if (ack || (n - grant_from == HOLD)) m_phase = M_COOL;
         end
         default: begin
            if (!sa && !sb) m_phase = M_IDLE;
         end
      endcase
   endtask

   task automatic check_outputs();
      chk("use_priority", {31'd0, bus.use_priority}, {31'd0, m_phase == M_GRANT});
      chk("busy",         {31'd0, bus.busy},         {31'd0, m_phase != M_IDLE});
      chk("priority",     {31'd0, bus.prio},         {31'd0, m_prio});
   endtask

   // one clock: drive after negedge, model at posedge, compare at next negedge
   task automatic cycle(input bit ra, input bit rb, input bit ack);
      bus.req_a     = ra;
      bus.req_b     = rb;
      bus.grant_ack = ack;
      @(posedge clk);
      if (reset_n) model_edge(ra, rb, ack);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      reset_n       = 1'b0;
      bus.req_a     = 1'b0;
      bus.req_b     = 1'b0;
      bus.grant_ack = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_use",  {31'd0, bus.use_priority}, 32'd0);
      chk("reset_busy", {31'd0, bus.busy},         32'd0);
      chk("reset_prio", {31'd0, bus.prio},         32'd0);
      reset_n = 1'b1;
   endtask

   // hard stop in case the run is stuck
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  rise;
      int  width;
      int  rises;
      int  busy_drop;
      int  winner;
      int  exp_w[3];
      bit  ack_next;
      bit  prev_use;
      bit  ra;
      bit  rb;
      bit  ack;

      n = 0;
`ifdef PRIO_ROUND_ROBIN_EN
      exp_w = '{1, 0, 1};
`else
      exp_w = '{1, 1, 1};
`endif
      do_reset();

      // T1: req_a held -> grant at edge 7, 16 cycles, busy drops 2 cycles after release
      rise  = -1;
      width = 0;
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, 1'b0, 1'b0);
         if (bus.use_priority === 1'b1) begin
            if (rise < 0) rise = i;
            width++;
         end
      end
      chk("t1_latency", rise, DEB + 3);
      chk("t1_width", width, HOLD);
      chk("t1_prio", {31'd0, bus.prio}, 32'd1);
      busy_drop = -1;
      for (int k = 0; k < 10; k++) begin
         cycle(1'b0, 1'b0, 1'b0);
         if (busy_drop < 0 && bus.busy === 1'b0) busy_drop = k;
      end
      chk("t1_busy_tail", busy_drop, 2);

      // T2: short req_b pulse aborts in debounce
      width = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(1'b0, i < 2, 1'b0);
         if (bus.use_priority === 1'b1) width++;
      end
      chk("t2_no_grant", width, 0);
      chk("t2_busy_idle", {31'd0, bus.busy}, 32'd0);

      // T3: req_b held, ack during the 3rd grant cycle
      width    = 0;
      ack_next = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cycle(1'b0, 1'b1, ack_next);
         ack_next = 1'b0;
         if (bus.use_priority === 1'b1) begin
            width++;
            if (width == 3) ack_next = 1'b1;
            chk("t3_prio", {31'd0, bus.prio}, 32'd0);
         end
      end
      chk("t3_width", width, 3);
      repeat (6) cycle(1'b0, 1'b0, 1'b0);

      // T4: three simultaneous requests from a fresh reset
      do_reset();
      for (int r = 0; r < 3; r++) begin
         winner = 2;
         for (int i = 0; i < 20 && winner == 2; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            if (bus.use_priority === 1'b1) winner = int'(bus.prio);
         end
         chk($sformatf("t4_winner%0d", r), winner, exp_w[r]);
         cycle(1'b0, 1'b0, 1'b1);
         repeat (6) cycle(1'b0, 1'b0, 1'b0);
      end

      // T5: reset in the 5th grant cycle, then re-debounce from idle
      width = 0;
      for (int i = 0; i < 30 && width < 5; i++) begin
         cycle(1'b1, 1'b0, 1'b0);
         if (bus.use_priority === 1'b1) width++;
      end
      chk("t5_reached_grant", width, 5);
      #2 reset_n = 1'b0;
      #1;
      chk("t5_async_use",  {31'd0, bus.use_priority}, 32'd0);
      chk("t5_async_busy", {31'd0, bus.busy},         32'd0);
      model_reset();
      repeat (2) cycle(1'b1, 1'b0, 1'b0);
      reset_n = 1'b1;
      rise = -1;
      for (int i = 0; i < 15; i++) begin
         cycle(1'b1, 1'b0, 1'b0);
         if (rise < 0 && bus.use_priority === 1'b1) rise = i;
      end
      chk("t5_relatency", rise, DEB + 3);
      repeat (30) cycle(1'b0, 1'b0, 1'b0);

      // T6: ack coincides with the timeout cycle; no second grant while held
      width    = 0;
      rises    = 0;
      prev_use = 1'b0;
      ack_next = 1'b0;
      for (int i = 0; i < 60; i++) begin
         cycle(1'b1, 1'b1, ack_next);
         ack_next = 1'b0;
         if (bus.use_priority === 1'b1) begin
            width++;
            if (!prev_use) rises++;
            if (width == HOLD) ack_next = 1'b1;
         end
         prev_use = bus.use_priority;
      end
      chk("t6_width", width, HOLD);
      chk("t6_single_grant", rises, 1);
      repeat (6) cycle(1'b0, 1'b0, 1'b0);

      // randomized traffic against the model
      do_reset();
      ra = 1'b0;
      rb = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) ra = ~ra;
         if ($urandom_range(0, 9) == 0) rb = ~rb;
         if ($urandom_range(0, 29) == 0) begin
            ra = 1'b1;
            rb = 1'b1;
         end
         ack = ($urandom_range(0, 11) == 0);
         cycle(ra, rb, ack);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
